// File: rtl/apb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// apb_rr_arbiter
//
// Shares one APB completer between NumReq requesters. A round-robin search
// picks the next owner in IDLE, its request is latched, and a standard
// SETUP -> ACCESS APB transfer is run. Completion (pready_i) or an optional
// ACCESS-phase timeout pulses rsp_valid_o back to the owner.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   req_valid_i         per-requester request, held until its response pulse
//   req_write_i         per-requester direction (1 = write)
//   req_addr_i          packed addresses, requester k at slice k
//   req_wdata_i         packed write data, requester k at slice k
//   rsp_valid_o         one-hot completion pulse to the owner
//   rsp_rdata_o         read data, valid with rsp_valid_o
//   rsp_err_o           pslverr or timeout, valid with rsp_valid_o
//   psel_o, penable_o, pwrite_o, paddr_o, pwdata_o   APB request
//   prdata_i, pready_i, pslverr_i                    APB response
//   grant_o             one-hot current owner (0 in IDLE)
//   busy_o              high outside IDLE
// ---------------------------------------------------------------------------
module apb_rr_arbiter #(
    parameter int NumReq        = 2,
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 255
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumReq-1:0]             req_valid_i,
    input  logic [NumReq-1:0]             req_write_i,
    input  logic [NumReq*AddrWidth-1:0]   req_addr_i,
    input  logic [NumReq*DataWidth-1:0]   req_wdata_i,
    output logic [NumReq-1:0]             rsp_valid_o,
    output logic [DataWidth-1:0]          rsp_rdata_o,
    output logic                          rsp_err_o,
    output logic                          psel_o,
    output logic                          penable_o,
    output logic                          pwrite_o,
    output logic [AddrWidth-1:0]          paddr_o,
    output logic [DataWidth-1:0]          pwdata_o,
    input  logic [DataWidth-1:0]          prdata_i,
    input  logic                          pready_i,
    input  logic                          pslverr_i,
    output logic [NumReq-1:0]             grant_o,
    output logic                          busy_o
);

    localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam bit TimeoutEn = (TimeoutCycles != 0);
    localparam logic [CntW-1:0] CntLast  = CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
    localparam logic [IdxW-1:0] LastInit = IdxW'(NumReq - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [IdxW-1:0]       r_last_grant;
    logic [NumReq-1:0]     r_grant;
    logic [CntW-1:0]       r_cnt;
    logic                  r_write;
    logic [AddrWidth-1:0]  r_addr;
    logic [DataWidth-1:0]  r_wdata;

    logic                  w_found;
    logic [IdxW-1:0]       w_win;
    logic [IdxW-1:0]       w_cand;
    logic [NumReq-1:0]     w_win_onehot;
    logic                  w_timeout_hit;

    // Unpack the flat request buses into per-requester arrays.
    logic [AddrWidth-1:0]  w_addr_arr  [NumReq];
    logic [DataWidth-1:0]  w_wdata_arr [NumReq];

    generate
        for (genvar gi = 0; gi < NumReq; gi++) begin : g_unpack
            assign w_addr_arr[gi]  = req_addr_i[gi*AddrWidth +: AddrWidth];
            assign w_wdata_arr[gi] = req_wdata_i[gi*DataWidth +: DataWidth];
        end
    endgenerate

    // Round-robin search: first valid requester at or after last_grant+1,
    // wrapping modulo NumReq. The last candidate visited is last_grant
    // itself, so a lone requester can win repeatedly.
    always_comb begin
        w_found      = 1'b0;
        w_win        = '0;
        w_cand       = '0;
        w_win_onehot = '0;
        for (int i = 1; i <= NumReq; i++) begin
            w_cand = IdxW'((int'(r_last_grant) + i) % NumReq);
            if (!w_found && req_valid_i[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
        w_win_onehot[w_win] = w_found;
    end

    assign w_timeout_hit = TimeoutEn && (r_cnt == CntLast);

    // Next state and APB/response outputs. The response path is suppressed
    // while rst_i is high so a transfer interrupted by reset never completes.
    always_comb begin
        w_state_next = r_state;
        psel_o       = 1'b0;
        penable_o    = 1'b0;
        rsp_valid_o  = '0;
        rsp_rdata_o  = '0;
        rsp_err_o    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_next = SETUP;
                end
            end
            SETUP: begin
                psel_o       = 1'b1;
                w_state_next = ACCESS;
            end
            ACCESS: begin
                psel_o    = 1'b1;
                penable_o = 1'b1;
                if (!rst_i) begin
                    if (pready_i) begin
                        // Normal completion wins over a coincident timeout.
                        rsp_valid_o  = r_grant;
                        rsp_rdata_o  = prdata_i;
                        rsp_err_o    = pslverr_i;
                        w_state_next = IDLE;
                    end else if (w_timeout_hit) begin
                        rsp_valid_o  = r_grant;
                        rsp_err_o    = 1'b1;
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_last_grant <= LastInit;
            r_grant      <= '0;
            r_cnt        <= '0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == IDLE && w_found) begin
                r_last_grant <= w_win;
                r_grant      <= w_win_onehot;
                r_cnt        <= '0;
                r_write      <= req_write_i[w_win];
                r_addr       <= w_addr_arr[w_win];
                r_wdata      <= w_wdata_arr[w_win];
            end
            if (r_state == ACCESS) begin
                if (w_state_next == IDLE) begin
                    r_grant <= '0;
                end else if (!pready_i && TimeoutEn) begin
                    r_cnt <= r_cnt + CntW'(1);
                end
            end
        end
    end

    // Address/data come straight from the latch so they hold between transfers.
    assign pwrite_o = r_write;
    assign paddr_o  = r_addr;
    assign pwdata_o = r_wdata;
    assign grant_o  = r_grant;
    assign busy_o   = (r_state != IDLE);

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_rr_arbiter
//
// Directed bench for apb_rr_arbiter (2 requesters, 32-bit APB, 8-cycle
// timeout). Inputs change on the falling edge; outputs are sampled 1 ns
// later, well away from the rising edge where the DUT updates.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_apb_rr_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  req_valid_i;
    logic [1:0]  req_write_i;
    logic [63:0] req_addr_i;
    logic [63:0] req_wdata_i;
    logic [1:0]  rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        psel_o;
    logic        penable_o;
    logic        pwrite_o;
    logic [31:0] paddr_o;
    logic [31:0] pwdata_o;
    logic [31:0] prdata_i;
    logic        pready_i;
    logic        pslverr_i;
    logic [1:0]  grant_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    apb_rr_arbiter #(
        .NumReq(2), .AddrWidth(32), .DataWidth(32), .TimeoutCycles(8)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_write_i(req_write_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
        .paddr_o(paddr_o), .pwdata_o(pwdata_o),
        .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1; req_valid_i = 2'b00; pready_i = 1'b0; pslverr_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; req_valid_i = 2'b00; req_write_i = 2'b00;
        req_addr_i = '0; req_wdata_i = '0;
        prdata_i = 32'hA5A5_A5A5; pready_i = 1'b1; pslverr_i = 1'b1;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0; pready_i = 1'b0; pslverr_i = 1'b0;
        #1;
        checks++; if (psel_o !== 1'b0) begin errors++; $display("FAIL reset_psel: got %b expected 0", psel_o); end
        checks++; if (penable_o !== 1'b0) begin errors++; $display("FAIL reset_penable: got %b expected 0", penable_o); end
        checks++; if (pwrite_o !== 1'b0) begin errors++; $display("FAIL reset_pwrite: got %b expected 0", pwrite_o); end
        checks++; if (paddr_o !== 32'h0) begin errors++; $display("FAIL reset_paddr: got %h expected 0", paddr_o); end
        checks++; if (pwdata_o !== 32'h0) begin errors++; $display("FAIL reset_pwdata: got %h expected 0", pwdata_o); end
        checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b expected 00", grant_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        checks++; if (rsp_valid_o !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid_o); end
        checks++; if (rsp_rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata: got %h expected 0", rsp_rdata_o); end
        checks++; if (rsp_err_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b expected 0", rsp_err_o); end
        $display("reset: %0d checks so far, %0d errors", checks, errors);
    endtask

    task automatic test_single_read();
        // IDLE cycle
        req_valid_i = 2'b01; req_write_i = 2'b00;
        req_addr_i[31:0] = 32'h0C00_0004; prdata_i = 32'hDEAD_BEEF; pready_i = 1'b1;
        #1;
        checks++; if (psel_o !== 1'b0) begin errors++; $display("FAIL rd_c0_psel: got %b expected 0", psel_o); end
        // SETUP cycle
        @(negedge clk_i); #1;
        checks++; if (psel_o !== 1'b1 || penable_o !== 1'b0) begin errors++; $display("FAIL rd_c1_setup: got psel=%b penable=%b expected 1/0", psel_o, penable_o); end
        checks++; if (paddr_o !== 32'h0C00_0004) begin errors++; $display("FAIL rd_c1_paddr: got %h expected 0c000004", paddr_o); end
        checks++; if (grant_o !== 2'b01) begin errors++; $display("FAIL rd_c1_grant: got %b expected 01", grant_o); end
        checks++; if (rsp_valid_o !== 2'b00) begin errors++; $display("FAIL rd_c1_rsp: got %b expected 00", rsp_valid_o); end
        // ACCESS cycle, completes immediately
        @(negedge clk_i); #1;
        checks++; if (penable_o !== 1'b1) begin errors++; $display("FAIL rd_c2_penable: got %b expected 1", penable_o); end
        checks++; if (rsp_valid_o !== 2'b01) begin errors++; $display("FAIL rd_c2_rsp_valid: got %b expected 01", rsp_valid_o); end
        checks++; if (rsp_rdata_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_c2_rdata: got %h expected deadbeef", rsp_rdata_o); end
        checks++; if (rsp_err_o !== 1'b0) begin errors++; $display("FAIL rd_c2_err: got %b expected 0", rsp_err_o); end
        // back to IDLE
        @(negedge clk_i);
        req_valid_i = 2'b00;
        #1;
        checks++; if (psel_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL rd_c3_idle: got psel=%b busy=%b expected 0/0", psel_o, busy_o); end
        checks++; if (rsp_valid_o !== 2'b00 || rsp_rdata_o !== 32'h0) begin errors++; $display("FAIL rd_c3_rsp_quiet: got valid=%b rdata=%h expected 00/0", rsp_valid_o, rsp_rdata_o); end
        checks++; if (paddr_o !== 32'h0C00_0004) begin errors++; $display("FAIL rd_c3_paddr_hold: got %h expected 0c000004", paddr_o); end
        $display("single_read: %0d checks so far, %0d errors", checks, errors);
    endtask

    task automatic test_contention();
        logic [1:0]  exp_g;
        logic [31:0] exp_a;
        do_reset();
        req_addr_i = {32'h0000_0200, 32'h0000_0100};
        req_write_i = 2'b00; prdata_i = 32'h0; pready_i = 1'b1;
        for (int t = 0; t < 4; t++) begin
            exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
            exp_a = (t % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200;
            req_valid_i = 2'b11;
            #1;
            checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL cont%0d_idle_busy: got %b expected 0", t, busy_o); end
            @(negedge clk_i); #1;
            checks++; if (grant_o !== exp_g || paddr_o !== exp_a) begin errors++; $display("FAIL cont%0d_grant: got grant=%b paddr=%h expected %b/%h", t, grant_o, paddr_o, exp_g, exp_a); end
            @(negedge clk_i); #1;
            checks++; if (rsp_valid_o !== exp_g) begin errors++; $display("FAIL cont%0d_rsp: got %b expected %b", t, rsp_valid_o, exp_g); end
            @(negedge clk_i);
        end
        req_valid_i = 2'b00;
        $display("contention: %0d checks so far, %0d errors", checks, errors);
    endtask

    task automatic test_wait_states();
        req_valid_i = 2'b01; req_write_i = 2'b01;
        req_addr_i[31:0] = 32'h0000_0010; req_wdata_i[31:0] = 32'h0000_0055;
        prdata_i = 32'h7777_7777; pready_i = 1'b0;
        @(negedge clk_i); #1;
        checks++; if (pwrite_o !== 1'b1 || pwdata_o !== 32'h55) begin errors++; $display("FAIL ws_setup: got pwrite=%b pwdata=%h expected 1/55", pwrite_o, pwdata_o); end
        // Disturb the inputs after grant: owner drops, other requester raises.
        req_addr_i[31:0] = 32'hFFFF_FFF0; req_wdata_i[31:0] = 32'h0000_00AA;
        req_write_i = 2'b00; req_valid_i = 2'b10;
        for (int w = 0; w < 4; w++) begin
            @(negedge clk_i); #1;
            checks++; if (penable_o !== 1'b1 || paddr_o !== 32'h10 || pwdata_o !== 32'h55 || pwrite_o !== 1'b1) begin errors++; $display("FAIL ws_wait%0d_stable: got pen=%b paddr=%h pwdata=%h pwrite=%b expected 1/10/55/1", w, penable_o, paddr_o, pwdata_o, pwrite_o); end
            checks++; if (rsp_valid_o !== 2'b00 || rsp_rdata_o !== 32'h0 || grant_o !== 2'b01) begin errors++; $display("FAIL ws_wait%0d_quiet: got rsp=%b rdata=%h grant=%b expected 00/0/01", w, rsp_valid_o, rsp_rdata_o, grant_o); end
        end
        @(negedge clk_i);
        pready_i = 1'b1;
        #1;
        checks++; if (paddr_o !== 32'h10 || penable_o !== 1'b1) begin errors++; $display("FAIL ws_last_stable: got paddr=%h pen=%b expected 10/1", paddr_o, penable_o); end
        checks++; if (rsp_valid_o !== 2'b01 || rsp_err_o !== 1'b0) begin errors++; $display("FAIL ws_done: got rsp=%b err=%b expected 01/0", rsp_valid_o, rsp_err_o); end
        @(negedge clk_i);
        req_valid_i = 2'b00; pready_i = 1'b0;
        #1;
        checks++; if (rsp_valid_o !== 2'b00 || busy_o !== 1'b0) begin errors++; $display("FAIL ws_single_pulse: got rsp=%b busy=%b expected 00/0", rsp_valid_o, busy_o); end
        $display("wait_states: %0d checks so far, %0d errors", checks, errors);
    endtask

    task automatic test_timeout();
        req_valid_i = 2'b10; req_write_i = 2'b00; req_addr_i[63:32] = 32'h0000_0300;
        prdata_i = 32'hFFFF_FFFF; pready_i = 1'b0;
        @(negedge clk_i);
        for (int a = 1; a <= 8; a++) begin
            @(negedge clk_i); #1;
            if (a < 8) begin
                checks++; if (rsp_valid_o !== 2'b00 || penable_o !== 1'b1) begin errors++; $display("FAIL to_access%0d: got rsp=%b pen=%b expected 00/1", a, rsp_valid_o, penable_o); end
            end else begin
                checks++; if (rsp_valid_o !== 2'b10 || rsp_err_o !== 1'b1 || rsp_rdata_o !== 32'h0) begin errors++; $display("FAIL to_fire: got rsp=%b err=%b rdata=%h expected 10/1/0", rsp_valid_o, rsp_err_o, rsp_rdata_o); end
            end
        end
        @(negedge clk_i);
        req_valid_i = 2'b00;
        #1;
        checks++; if (psel_o !== 1'b0 || grant_o !== 2'b00 || busy_o !== 1'b0) begin errors++; $display("FAIL to_after: got psel=%b grant=%b busy=%b expected 0/00/0", psel_o, grant_o, busy_o); end
        $display("timeout: %0d checks so far, %0d errors", checks, errors);
    endtask

    task automatic test_timeout_precedence();
        req_valid_i = 2'b01; req_write_i = 2'b00; prdata_i = 32'h1234_5678; pready_i = 1'b0;
        @(negedge clk_i);
        for (int a = 1; a <= 7; a++) @(negedge clk_i);
        @(negedge clk_i);
        pready_i = 1'b1;
        #1;
        checks++; if (rsp_valid_o !== 2'b01 || rsp_err_o !== 1'b0 || rsp_rdata_o !== 32'h1234_5678) begin errors++; $display("FAIL to_prec: got rsp=%b err=%b rdata=%h expected 01/0/12345678", rsp_valid_o, rsp_err_o, rsp_rdata_o); end
        @(negedge clk_i);
        req_valid_i = 2'b00; pready_i = 1'b0;
        $display("timeout_precedence: %0d checks so far, %0d errors", checks, errors);
    endtask

    task automatic test_slave_error();
        req_valid_i = 2'b10; prdata_i = 32'h0000_0BAD; pready_i = 1'b1; pslverr_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i); #1;
        checks++; if (rsp_valid_o !== 2'b10 || rsp_err_o !== 1'b1) begin errors++; $display("FAIL serr_pulse: got rsp=%b err=%b expected 10/1", rsp_valid_o, rsp_err_o); end
        @(negedge clk_i);
        req_valid_i = 2'b01; pslverr_i = 1'b0; prdata_i = 32'h0000_0600;
        #1;
        checks++; if (rsp_err_o !== 1'b0) begin errors++; $display("FAIL serr_idle_err: got %b expected 0", rsp_err_o); end
        @(negedge clk_i); #1;
        checks++; if (grant_o !== 2'b01) begin errors++; $display("FAIL serr_next_grant: got %b expected 01", grant_o); end
        @(negedge clk_i); #1;
        checks++; if (rsp_valid_o !== 2'b01 || rsp_err_o !== 1'b0 || rsp_rdata_o !== 32'h600) begin errors++; $display("FAIL serr_next_rsp: got rsp=%b err=%b rdata=%h expected 01/0/600", rsp_valid_o, rsp_err_o, rsp_rdata_o); end
        @(negedge clk_i);
        req_valid_i = 2'b00; pready_i = 1'b0;
        $display("slave_error: %0d checks so far, %0d errors", checks, errors);
    endtask

    task automatic test_reset_mid();
        req_valid_i = 2'b10; pready_i = 1'b0; prdata_i = 32'h0;
        @(negedge clk_i);
        @(negedge clk_i); #1;
        checks++; if (grant_o !== 2'b10 || penable_o !== 1'b1) begin errors++; $display("FAIL rmid_access: got grant=%b pen=%b expected 10/1", grant_o, penable_o); end
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        checks++; if (rsp_valid_o !== 2'b00) begin errors++; $display("FAIL rmid_no_pulse: got %b expected 00", rsp_valid_o); end
        @(negedge clk_i);
        rst_i = 1'b0; req_valid_i = 2'b11;
        #1;
        checks++; if (psel_o !== 1'b0 || grant_o !== 2'b00 || rsp_valid_o !== 2'b00) begin errors++; $display("FAIL rmid_after: got psel=%b grant=%b rsp=%b expected 0/00/00", psel_o, grant_o, rsp_valid_o); end
        @(negedge clk_i); #1;
        checks++; if (grant_o !== 2'b01) begin errors++; $display("FAIL rmid_req0_first: got %b expected 01", grant_o); end
        @(negedge clk_i);
        pready_i = 1'b1;
        #1;
        checks++; if (rsp_valid_o !== 2'b01) begin errors++; $display("FAIL rmid_resume: got %b expected 01", rsp_valid_o); end
        @(negedge clk_i);
        req_valid_i = 2'b00; pready_i = 1'b0;
        $display("reset_mid: %0d checks so far, %0d errors", checks, errors);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_wait_states();
        test_timeout();
        test_timeout_precedence();
        test_slave_error();
        test_reset_mid();
        repeat (2) @(negedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
